// File: rtl/mips_regfile_reader_if.sv
// mips_regfile_reader_if: register file bus; master drives we/waddr/wdata/re/raddr1/raddr2, slave returns rdata1/rdata2/rvalid
interface mips_regfile_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              rvalid;
  modport master (output we, waddr, wdata, re, raddr1, raddr2, input rdata1, rdata2, rvalid);
  modport slave  (input we, waddr, wdata, re, raddr1, raddr2, output rdata1, rdata2, rvalid);
endinterface

// File: rtl/mips_regfile_reader.sv
// mips_regfile_reader: 2R1W register file, $zero hardwired, registered reads with write bypass; clk, sync active-low rst_n, bus (slave)
module mips_regfile_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic clk,
  input logic rst_n,
  mips_regfile_reader_if.slave bus
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] mem_d [2**ADDR_W];
  logic [DATA_W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic              rvalid_q, rvalid_d;
  always_comb begin
    mem_d = mem_q;
    if (bus.we) mem_d[bus.waddr] = bus.wdata;
    mem_d[0] = '0;
    rdata1_d = bus.re ? mem_d[bus.raddr1] : rdata1_q;
    rdata2_d = bus.re ? mem_d[bus.raddr2] : rdata2_q;
    rvalid_d = bus.re;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rdata1_q <= '0;
      rdata2_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      rvalid_q <= rvalid_d;
    end
  end
  assign bus.rdata1 = rdata1_q;
  assign bus.rdata2 = rdata2_q;
  assign bus.rvalid = rvalid_q;
endmodule

// File: tb/tb_mips_regfile_reader.sv
// tb_mips_regfile_reader: scoreboard bench with directed cases and randomized traffic against an array reference model
module tb_mips_regfile_reader;
  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;
  logic [31:0] ref_mem [32];
  exp_t exp_q [$];
  logic exp_rv = 1'b0;
  logic [31:0] exp_h1 = '0, exp_h2 = '0;
  mips_regfile_reader_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  mips_regfile_reader #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step(input logic rn, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic re, input logic [4:0] a1, input logic [4:0] a2);
    rst_n = rn;
    bus.we = we;
    bus.waddr = wa;
    bus.wdata = wd;
    bus.re = re;
    bus.raddr1 = a1;
    bus.raddr2 = a2;
    @(posedge clk);
    #1;
    if (!rn) begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
      exp_q.delete();
      exp_rv = 1'b0;
      exp_h1 = '0;
      exp_h2 = '0;
    end else begin
      if (we && wa != 0) ref_mem[wa] = wd;
      exp_rv = re;
      if (re) begin
        exp_h1 = ref_mem[a1];
        exp_h2 = ref_mem[a2];
        exp_q.push_back('{d1: exp_h1, d2: exp_h2});
      end
    end
  endtask
  always @(negedge clk) begin
    if (checking) begin
      tests++;
      if (bus.rvalid !== exp_rv) begin
        fails++;
        $display("FAIL rvalid t=%0t got %b want %b", $time, bus.rvalid, exp_rv);
      end
      if (bus.rvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_rvalid t=%0t got rvalid=1 want no pending read", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          tests++;
          if (bus.rdata1 !== e.d1 || bus.rdata2 !== e.d2) begin
            fails++;
            $display("FAIL read_data t=%0t got %h/%h want %h/%h", $time, bus.rdata1, bus.rdata2, e.d1, e.d2);
          end
        end
      end else begin
        tests++;
        if (bus.rdata1 !== exp_h1 || bus.rdata2 !== exp_h2) begin
          fails++;
          $display("FAIL hold_data t=%0t got %h/%h want %h/%h", $time, bus.rdata1, bus.rdata2, exp_h1, exp_h2);
        end
      end
    end
  end
  initial begin
    foreach (ref_mem[i]) ref_mem[i] = '0;
    step(0, 1, 5'd4, 32'hDEAD_BEEF, 1, 5'd4, 5'd4);
    checking = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 5'd5, 5'd31);
    step(1, 1, 5'd8, 32'h00AB_CDEF, 0, 0, 0);
    step(1, 0, 0, 0, 1, 5'd8, 5'd31);
    step(1, 1, 5'd9, 32'h1234_5678, 1, 5'd9, 5'd9);
    step(1, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 5'd9);
    step(1, 0, 0, 0, 1, 5'd0, 5'd0);
    step(1, 0, 0, 0, 1, 5'd8, 5'd8);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 5'(i + 1), 5'(i + 9));
    step(1, 1, 5'd3, 32'h1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 5'd3, 5'd8);
    step(0, 1, 5'd3, 32'h5555_5555, 1, 5'd3, 5'd3);
    step(1, 0, 0, 0, 1, 5'd3, 5'd8);
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa, a1, a2;
      wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 5) == 0) ? a1 : 5'($urandom_range(0, 31));
      step($urandom_range(0, 39) != 0, 1'($urandom), wa, $urandom, 1'($urandom), a1, a2);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    checking = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending reads want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
